// File: rtl/mpu341_int_pkg.sv
// mpu341_int_pkg: shared FSM state type and constants for the interrupt controller.
package mpu341_int_pkg;
    localparam int NUM_IRQ = 4;
    localparam int IDX_W = $clog2(NUM_IRQ);
    localparam logic [1:0] VEC_PREFIX = 2'b11;
    typedef enum logic [1:0] {IDLE, VECTOR, SERVICE, RETURN} int_state_t;
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: fixed-priority encoder, lowest set index wins.
module irq_prio_enc
    import mpu341_int_pkg::*;
(
    input  logic [NUM_IRQ-1:0] req,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);
    assign valid = |req;
    always_comb begin
        idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (req[i]) idx = i[IDX_W-1:0];
    end
endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: non-nesting vectored interrupt FSM overriding the sequencer address.
// Define INT_MASK_EN to add a writable per-source enable mask (otherwise all sources enabled).
module interrupt_controller
    import mpu341_int_pkg::*;
(
    input  logic               clk,
    input  logic               sync_reset_n,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [7:0]         pc,
    input  logic               reti,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_data,
    output logic               ovr_en,
    output logic [7:0]         ovr_addr,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic               int_active,
    output logic [IDX_W-1:0]   int_id
);
    int_state_t         state, state_nxt;
    logic [7:0]         ret_addr;
    logic [NUM_IRQ-1:0] mask;
    logic               pend_vld;
    logic [IDX_W-1:0]   pend_idx;

`ifdef INT_MASK_EN
    always_ff @(posedge clk) begin
        if (!sync_reset_n) mask <= '1;
        else if (mask_we) mask <= mask_data;
    end
`else
    logic unused_mask_in;
    assign mask = '1;
    assign unused_mask_in = ^{mask_we, mask_data};
`endif

    irq_prio_enc u_prio (
        .req   (irq & mask),
        .valid (pend_vld),
        .idx   (pend_idx)
    );

    always_ff @(posedge clk) begin
        if (!sync_reset_n) begin
            state    <= IDLE;
            int_id   <= '0;
            ret_addr <= 8'h00;
        end else begin
            state <= state_nxt;
            if (state == IDLE && pend_vld) int_id <= pend_idx;
            if (state == VECTOR) ret_addr <= pc + 8'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = pend_vld ? VECTOR : IDLE;
            VECTOR:  state_nxt = SERVICE;
            SERVICE: state_nxt = reti ? RETURN : SERVICE;
            RETURN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign ovr_en     = (state == VECTOR) || (state == RETURN);
    assign ovr_addr   = (state == VECTOR) ? {VEC_PREFIX, int_id, 4'h0} :
                        (state == RETURN) ? ret_addr : 8'h00;
    assign irq_ack    = (state == VECTOR) ? NUM_IRQ'(1) << int_id : '0;
    assign int_active = state != IDLE;
endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-002 SHALL have port sync_reset_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port irq  input  4  level interrupt requests; bit 0 highest priority.
REQ-004 SHALL have port pc  input  8  current program counter from program sequencer.
REQ-005 SHALL have port reti  input  1  decoded return-from-interrupt instruction, one cycle.
REQ-006 SHALL have port mask_we  input  1  mask register write strobe (used only with INT_MASK_EN).
REQ-007 SHALL have port mask_data  input  4  new mask value, 1 = enabled (used only with INT_MASK_EN).
REQ-008 SHALL have port ovr_en  output  1  forces program sequencer pm_addr to ovr_addr this cycle.
REQ-009 SHALL have port ovr_addr  output  8  override address (vector or return address).
REQ-010 SHALL have port irq_ack  output  4  one-hot acknowledge pulse to serviced source.
REQ-011 SHALL have port int_active  output  1  high while in VECTOR, SERVICE or RETURN.
REQ-012 SHALL have port int_id  output  2  index of interrupt being serviced.

Function
REQ-013 SHALL implement FSM states IDLE, VECTOR, SERVICE, RETURN.
REQ-014 In IDLE, SHALL select the lowest-index bit of (irq AND mask); if any, latch it into int_id and go to VECTOR next cycle.
REQ-015 In VECTOR (one cycle), SHALL drive ovr_en=1, ovr_addr={2'b11,int_id,4'h0} (C0/D0/E0/F0), pulse irq_ack[int_id], capture ret_addr=pc+1 with FF wrapping to 00, then go to SERVICE.
REQ-016 Vector SHALL be taken even if the request deasserts between IDLE detection and VECTOR.
REQ-017 In SERVICE, ovr_en=0; SHALL stay until reti=1, then go to RETURN.
REQ-018 In RETURN (one cycle), SHALL drive ovr_en=1, ovr_addr=ret_addr, then go to IDLE.
REQ-019 SHALL not nest: irq is ignored in VECTOR, SERVICE and RETURN; pending levels are re-evaluated in IDLE, so the earliest next VECTOR is 2 cycles after RETURN.
REQ-020 reti in IDLE or VECTOR SHALL be ignored.
REQ-021 ovr_en SHALL be 0 and ovr_addr SHALL be 8'h00 in IDLE and SERVICE.
REQ-022 Interrupt latency SHALL be exactly 1 cycle from irq sampled in IDLE to the VECTOR override.

Reset
REQ-023 When sync_reset_n=0 at a rising edge, SHALL enter IDLE: ovr_en=0, ovr_addr=00, irq_ack=0, int_active=0, int_id=0, ret_addr=00, mask=4'hF.
REQ-024 Reset in any state, including mid-VECTOR or mid-SERVICE, SHALL abandon the interrupt with no RETURN override.

Configuration
REQ-025 With INT_MASK_EN defined, SHALL hold a 4-bit mask register, loaded from mask_data when mask_we=1 (any state) and effective from the next IDLE evaluation.
REQ-026 Without INT_MASK_EN, the mask SHALL be constant 4'hF, and mask_we and mask_data SHALL be ignored.

Structure
REQ-027 Package mpu341_int_pkg SHALL hold the FSM state enum, NUM_IRQ=4 and the vector base nibble prefix 2'b11.
REQ-028 Priority selection SHALL be a sub-module irq_prio_enc (4-bit in -> valid plus 2-bit index).

Verification
REQ-029 irq=4'b0100 in IDLE, pc=8'h37 -> next cycle ovr_en=1, ovr_addr=E0, irq_ack=0100; later reti -> RETURN ovr_addr=38.
REQ-030 irq=4'b1010 simultaneously -> int_id=1, ovr_addr=D0; after RETURN with irq[3] still high -> vector F0 two cycles later.
REQ-031 pc=8'hFF at VECTOR -> RETURN ovr_addr=00 (wrap).
REQ-032 irq[0] asserted during SERVICE of id 2 -> no override until RETURN completes; then vector C0.
REQ-033 sync_reset_n=0 during SERVICE -> IDLE, all outputs 0; a subsequent reti produces no override.
REQ-034 With INT_MASK_EN: write mask=4'b1110, irq=4'b0001 -> no vector; write mask=4'hF -> vector C0.
